// File: rtl/legv8_ctrl_pkg.sv
// ============================================================================
// legv8_ctrl_pkg : shared LEGv8 control types, opcode constants and encodings
// Revision: 1.0
// ============================================================================
`default_nettype none

package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_CBZ_EXEC  = 4'd9,
    S_B_EXEC    = 4'd10,
    S_TRAP      = 4'd11
  } state_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM9 = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  typedef struct packed {
    logic mem_ld;
    logic mem_st;
    logic rtype;
    logic cbz;
    logic b;
    logic illegal;
  } op_class_t;

endpackage

`default_nettype wire

// File: rtl/opcode_classifier.sv
// ============================================================================
// opcode_classifier : one-hot opcode class decode, shared with single-cycle path
// Revision: 1.0
// ============================================================================
`default_nettype none

module opcode_classifier
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class
);

  always_comb begin
    op_class         = '0;
    op_class.mem_ld  = (opcode == OP_LDUR);
    op_class.mem_st  = (opcode == OP_STUR);
    op_class.rtype   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                       (opcode == OP_AND) || (opcode == OP_ORR);
    op_class.cbz     = (opcode[10:3] == OP_CBZ_PFX);
    op_class.b       = (opcode[10:5] == OP_B_PFX);
    op_class.illegal = !(op_class.mem_ld || op_class.mem_st || op_class.rtype ||
                         op_class.cbz || op_class.b);
  end

endmodule

`default_nettype wire

// File: rtl/main_control_fsm.sv
// ============================================================================
// main_control_fsm : multicycle LEGv8 main control (Moore FSM + memory handshake)
// Optional: ILLEGAL_TRAP_EN -- undecoded opcodes lock into TRAP until reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module main_control_fsm
  import legv8_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  input  logic        mem_ack,
  output logic [1:0]  ALUOp,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        Reg2Loc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        trap
);

  state_e    state_q, state_d;
  op_class_t op_class;

  opcode_classifier u_classifier (
    .opcode   (opcode),
    .op_class (op_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    Reg2Loc     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    trap        = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // PC+4 and IR load commit only in the cycle memory returns the word
        if (mem_ack) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        ALUSrcB = SRCB_BR;
        Reg2Loc = op_class.cbz || op_class.mem_st;
        if (op_class.mem_ld || op_class.mem_st) state_d = S_MEM_ADDR;
        else if (op_class.rtype)                state_d = S_R_EXEC;
        else if (op_class.cbz)                  state_d = S_CBZ_EXEC;
        else if (op_class.b)                    state_d = S_B_EXEC;
`ifdef ILLEGAL_TRAP_EN
        else if (op_class.illegal)              state_d = S_TRAP;
`else
        else if (op_class.illegal)              state_d = S_FETCH;
`endif
        else                                    state_d = S_FETCH;
      end

      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM9;
        state_d = op_class.mem_ld ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ack) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        if (mem_ack) state_d = S_FETCH;
      end

      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_RTYPE;
        state_d = S_R_WB;
      end

      S_R_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_CBZ_EXEC: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_PASSB;
        Reg2Loc     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        state_d     = S_FETCH;
      end

      S_B_EXEC: begin
        PCWrite  = 1'b1;
        PCSource = 1'b1;
        state_d  = S_FETCH;
      end

      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        trap    = 1'b1;
        state_d = S_TRAP;
`else
        state_d = S_RESET;
`endif
      end

      default: state_d = S_RESET;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_main_control_fsm.sv
// ============================================================================
// tb_main_control_fsm : per-instruction expected control-vector sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_main_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] opcode;
  logic        mem_ack;
  logic [1:0]  ALUOp, ALUSrcB;
  logic        ALUSrcA, Reg2Loc, MemRead, MemWrite, IorD, IRWrite;
  logic        RegWrite, MemToReg, PCWrite, PCWriteCond, PCSource, trap;

  main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ack(mem_ack),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Reg2Loc(Reg2Loc),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       r2l, mrd, mwr, iord, irw, rgw, m2r, pcw, pcwc, pcs, trap;
  } ctl_t;

  localparam int K_LD = 0, K_ST = 1, K_R = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

  ctl_t obs;
  assign obs = {ALUOp, ALUSrcA, ALUSrcB, Reg2Loc, MemRead, MemWrite, IorD,
                IRWrite, RegWrite, MemToReg, PCWrite, PCWriteCond, PCSource, trap};

  int   checks;
  int   failures;
  ctl_t q_e[$];
  logic q_a[$];

  function automatic int classify(input logic [10:0] op);
    if (op == 11'b11111000010) return K_LD;
    if (op == 11'b11111000000) return K_ST;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return K_R;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op[10:5] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  function automatic logic [10:0] gen_op(input int cls);
    logic [10:0] r;
    logic [10:0] rt [4];
    rt = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    case (cls)
      K_LD:  r = 11'b11111000010;
      K_ST:  r = 11'b11111000000;
      K_R:   r = rt[$urandom_range(0, 3)];
      K_CBZ: r = {8'b10110100, 3'($urandom_range(0, 7))};
      K_B:   r = {6'b000101, 5'($urandom_range(0, 31))};
      default: begin
        r = 11'($urandom);
        while (classify(r) != K_ILL) r = 11'($urandom);
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input ctl_t e);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    checks++;
    assert (!(MemRead && MemWrite)) else begin
      failures++;
      $error("FAIL %s_rd_wr_both observed=1 expected=0", tag);
    end
  endtask

  task automatic push(input ctl_t e, input logic a);
    q_e.push_back(e);
    q_a.push_back(a);
  endtask

  // Expected per-cycle control vectors for one instruction, from FETCH entry
  task automatic build(input int cls, input int fw, input int dw);
    ctl_t c;
    c = '0; c.mrd = 1'b1; c.srcb = 2'b01;
    repeat (fw) push(c, 1'b0);
    c.irw = 1'b1; c.pcw = 1'b1;
    push(c, 1'b1);
    c = '0; c.srcb = 2'b11; c.r2l = (cls == K_CBZ) || (cls == K_ST);
    push(c, 1'($urandom_range(0, 1)));
    case (cls)
      K_LD, K_ST: begin
        c = '0; c.srca = 1'b1; c.srcb = 2'b10;
        push(c, 1'($urandom_range(0, 1)));
        c = '0; c.iord = 1'b1;
        if (cls == K_LD) c.mrd = 1'b1; else begin c.mwr = 1'b1; c.r2l = 1'b1; end
        repeat (dw) push(c, 1'b0);
        push(c, 1'b1);
        if (cls == K_LD) begin
          c = '0; c.rgw = 1'b1; c.m2r = 1'b1;
          push(c, 1'($urandom_range(0, 1)));
        end
      end
      K_R: begin
        c = '0; c.srca = 1'b1; c.aluop = 2'b10;
        push(c, 1'($urandom_range(0, 1)));
        c = '0; c.rgw = 1'b1;
        push(c, 1'($urandom_range(0, 1)));
      end
      K_CBZ: begin
        c = '0; c.srca = 1'b1; c.aluop = 2'b01; c.r2l = 1'b1; c.pcwc = 1'b1; c.pcs = 1'b1;
        push(c, 1'($urandom_range(0, 1)));
      end
      K_B: begin
        c = '0; c.pcw = 1'b1; c.pcs = 1'b1;
        push(c, 1'($urandom_range(0, 1)));
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        c = '0; c.trap = 1'b1;
        repeat (4) push(c, 1'($urandom_range(0, 1)));
`endif
      end
    endcase
  endtask

  task automatic play(input string tag);
    for (int i = 0; i < q_e.size(); i++) begin
      mem_ack = q_a[i];
      #1 check($sformatf("%s[%0d]", tag, i), q_e[i]);
      @(negedge clk);
    end
    q_e.delete();
    q_a.delete();
  endtask

  task automatic do_reset(input string tag);
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    #1 check({tag, "_assert"}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check({tag, "_release"}, '0);
    @(negedge clk);
  endtask

  initial begin
    int cls;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    opcode   = '0;
    mem_ack  = 1'b0;
    @(negedge clk);
    #1 check("reset_state", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release", '0);
    @(negedge clk);

    opcode = 11'b10001011000; build(K_R, 3, 0);   play("add_fetch_wait3");
    opcode = 11'b11111000010; build(K_LD, 0, 2);  play("ldur_wait2");
    opcode = gen_op(K_CBZ);   build(K_CBZ, 0, 0); play("cbz");
    opcode = gen_op(K_B);     build(K_B, 0, 0);   play("b");
    opcode = 11'b11111000000; build(K_ST, 1, 1);  play("stur");
    opcode = 11'b00000000000; build(K_ILL, 0, 0); play("illegal");
`ifdef ILLEGAL_TRAP_EN
    do_reset("trap_reset");
`endif

    // STUR interrupted by reset while its write is still outstanding
    opcode = 11'b11111000000;
    build(K_ST, 0, 3);
    q_e = q_e[0:3];
    q_a = q_a[0:3];
    play("stur_pre_reset");
    do_reset("stur_reset");
    opcode = gen_op(K_B); build(K_B, 0, 0); play("b_after_reset");

    for (int n = 0; n < 60; n++) begin
      cls    = $urandom_range(0, 5);
      opcode = gen_op(cls);
      build(cls, $urandom_range(0, 2), $urandom_range(0, 2));
      play($sformatf("rand%0d_cls%0d", n, cls));
`ifdef ILLEGAL_TRAP_EN
      if (cls == K_ILL) do_reset($sformatf("rand%0d_trap_reset", n));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
